// File: rtl/pc_control_unit.sv
// Program-counter control: next-PC arbitration across exception/branch/jump/return/stall,
// with a circular return-address stack fed by jump+call and drained by ret.
module pc_control_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             exception,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = RAS_DEPTH;
    localparam logic [WIDTH-1:0] PC_STEP  = 4;
    localparam logic [WIDTH-1:0] ALIGN    = ~{{(WIDTH-2){1'b0}}, 2'b11};

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_EXC,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_RET
    } pc_sel_t;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] ras_count;
    logic [WIDTH-1:0] ras_top;

    pc_sel_t          pc_sel;
    logic             push;
    logic             pop;
    logic             underflow_req;
    logic [WIDTH-1:0] next_pc;

    assign pc_plus4  = pc_out + PC_STEP;
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_FULL);

    // wr_ptr is the next free slot; when full it points at the oldest entry,
    // so a push while full naturally overwrites it.
    assign top_ptr = wr_ptr - PTR_ONE;
    assign ras_top = ras_mem[top_ptr];

    // Only the winning redirect may touch the stack; an empty-stack ret that
    // would otherwise have won drops to stall/sequential and flags underflow.
    always_comb begin
        pc_sel        = SEL_SEQ;
        push          = 1'b0;
        pop           = 1'b0;
        underflow_req = 1'b0;
        if (exception) begin
            pc_sel = SEL_EXC;
        end else if (branch_taken) begin
            pc_sel = SEL_BRANCH;
        end else if (jump) begin
            pc_sel = SEL_JUMP;
            push   = call;
        end else if (ret && !ras_empty) begin
            pc_sel = SEL_RET;
            pop    = 1'b1;
        end else begin
            underflow_req = ret;
            pc_sel        = stall ? SEL_HOLD : SEL_SEQ;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            SEL_EXC:    next_pc = EXC_VECTOR & ALIGN;
            SEL_BRANCH: next_pc = branch_target & ALIGN;
            SEL_JUMP:   next_pc = jump_target & ALIGN;
            SEL_RET:    next_pc = ras_top & ALIGN;
            SEL_HOLD:   next_pc = pc_out;
            default:    next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out        <= RESET_VECTOR;
            wr_ptr        <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc_out        <= next_pc;
            ras_underflow <= underflow_req;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_ONE;
                end
            end else if (pop) begin
                wr_ptr    <= top_ptr;
                ras_count <= ras_count - CNT_ONE;
            end
        end
    end

    // Storage carries no reset: validity is tracked entirely by ras_count.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[wr_ptr] <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit: arbitration, alignment, return stack, reset.
module tb_pc_control_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        exception;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        call;
    logic        ret;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;

    int tests_run = 0;
    int tests_failed = 0;

    pc_control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .exception     (exception),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic e, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt,
                         input logic c, input logic r, input logic s);
        exception     = e;
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        call          = c;
        ret           = r;
        stall         = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step(input string tag, input logic [31:0] exp_pc);
        @(posedge clk);
        #1;
        check(tag, pc_out, exp_pc);
    endtask

    logic [31:0] ret_addrs [4];

    initial begin
        rst_n = 1'b0;
        idle();
        // A redirect presented during reset must be discarded.
        drive(1'b0, 1'b1, 32'h0000_0700, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_pc", pc_out, 32'h0);
        check("rst_plus4", pc_plus4, 32'h4);
        check("rst_empty", {31'b0, ras_empty}, 32'h1);
        check("rst_full", {31'b0, ras_full}, 32'h0);
        check("rst_ovf", {31'b0, ras_overflow}, 32'h0);
        check("rst_udf", {31'b0, ras_underflow}, 32'h0);
        idle();
        rst_n = 1'b1;

        step("seq_4", 32'h4);
        step("seq_8", 32'h8);
        step("seq_c", 32'hC);
        step("seq_10", 32'h10);

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step("stall_1", 32'h10);
        step("stall_2", 32'h10);
        drive(1'b0, 1'b1, 32'h0000_0203, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step("br_over_stall_align", 32'h200);

        drive(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step("br_to_40", 32'h40);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
        step("call_100", 32'h100);
        check("call_nonempty", {31'b0, ras_empty}, 32'h0);
        check("plus4_104", pc_plus4, 32'h104);
        idle();
        step("seq_104", 32'h104);
        step("seq_108", 32'h108);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step("ret_44", 32'h44);
        check("ret_empty", {31'b0, ras_empty}, 32'h1);
        check("ret_no_udf", {31'b0, ras_underflow}, 32'h0);

        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0302, 1'b1, 1'b0, 1'b0);
        step("call_302_align", 32'h300);
        drive(1'b1, 1'b1, 32'h0000_0900, 1'b1, 32'h0000_0904, 1'b1, 1'b0, 1'b0);
        step("exc_wins", 32'h80);
        check("exc_nonempty", {31'b0, ras_empty}, 32'h0);
        check("exc_not_full", {31'b0, ras_full}, 32'h0);
        drive(1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step("br_over_ret", 32'h500);
        check("br_ret_nonempty", {31'b0, ras_empty}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step("ret_48", 32'h48);
        check("ret48_empty", {31'b0, ras_empty}, 32'h1);

        step("udf_seq", 32'h4C);
        check("udf_pulse", {31'b0, ras_underflow}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step("udf_stall_hold", 32'h4C);
        check("udf_pulse_2", {31'b0, ras_underflow}, 32'h1);
        idle();
        step("seq_50", 32'h50);
        check("udf_clear", {31'b0, ras_underflow}, 32'h0);

        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0600, 1'b1, 1'b1, 1'b0);
        step("jcr_jump", 32'h600);
        check("jcr_no_udf", {31'b0, ras_underflow}, 32'h0);
        check("jcr_pushed", {31'b0, ras_empty}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step("jcr_ret_54", 32'h54);
        check("jcr_empty", {31'b0, ras_empty}, 32'h1);

        // Five calls into a four-deep stack; the first return address is lost.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 32'(i) << 12, 1'b1, 1'b0, 1'b0);
            step("call_n", 32'(i) << 12);
        end
        check("five_full", {31'b0, ras_full}, 32'h1);
        check("five_ovf", {31'b0, ras_overflow}, 32'h1);
        ret_addrs[0] = 32'h4004;
        ret_addrs[1] = 32'h3004;
        ret_addrs[2] = 32'h2004;
        ret_addrs[3] = 32'h1004;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("ret_n", ret_addrs[i]);
            check("ret_n_ovf", {31'b0, ras_overflow}, 32'h1);
        end
        check("four_ret_empty", {31'b0, ras_empty}, 32'h1);
        step("fifth_ret_seq", 32'h1008);
        check("fifth_ret_udf", {31'b0, ras_underflow}, 32'h1);
        check("fifth_ret_ovf", {31'b0, ras_overflow}, 32'h1);

        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
        step("call_top", 32'hFFFF_FFF8);
        idle();
        step("seq_fffc", 32'hFFFF_FFFC);
        check("plus4_wrap", pc_plus4, 32'h0);
        step("wrap_0", 32'h0);
        step("wrap_4", 32'h4);

        #2;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0A00, 1'b0, 1'b0, 1'b0);
        #1;
        check("async_rst_pc", pc_out, 32'h0);
        check("async_rst_empty", {31'b0, ras_empty}, 32'h1);
        check("async_rst_ovf", {31'b0, ras_overflow}, 32'h0);
        check("async_rst_udf", {31'b0, ras_underflow}, 32'h0);
        idle();
        rst_n = 1'b1;
        step("post_rst_4", 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
